// File: rtl/bitstream_feeder_pkg.sv
// Shared types and constants for the JPEG scan bitstream feeder.
// Markers are matched on the byte that follows a 0xFF prefix.
package bitstream_feeder_pkg;

    localparam int unsigned IN_BUS_WIDTH = 32;

    typedef enum logic [2:0] {
        StIdle,
        StRun,
        StFfSeen,
        StFlush,
        StDone
    } feed_state_e;

    localparam logic [7:0] M_STUFF = 8'h00;
    localparam logic [7:0] M_FILL  = 8'hFF;
    localparam logic [7:0] M_EOI   = 8'hD9;
    localparam logic [7:0] M_RST0  = 8'hD0;
    localparam logic [7:0] M_RST7  = 8'hD7;

    function automatic logic is_rst_marker(input logic [7:0] b);
        return (b >= M_RST0) && (b <= M_RST7);
    endfunction

endpackage

// File: rtl/bitstream_feeder_word_fifo.sv
// First-word-fall-through word FIFO; rdata shows the head entry whenever empty is low.
// DEPTH must be a power of two so the pointers wrap naturally.
module bitstream_feeder_word_fifo #(
    parameter int unsigned WIDTH = 32,
    parameter int unsigned DEPTH = 8
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       push,
    input  logic [WIDTH-1:0]           wdata,
    input  logic                       pop,
    output logic [WIDTH-1:0]           rdata,
    output logic [$clog2(DEPTH+1)-1:0] count,
    output logic                       full,
    output logic                       empty
);

    localparam int unsigned PtrW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int unsigned CntW = $clog2(DEPTH + 1);

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [PtrW-1:0]  wptr_q, rptr_q;
    logic [CntW-1:0]  count_q;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wptr_q  <= '0;
            rptr_q  <= '0;
            count_q <= '0;
        end else begin
            if (push) wptr_q <= wptr_q + PtrW'(1);
            if (pop)  rptr_q <= rptr_q + PtrW'(1);
            unique case ({push, pop})
                2'b10:   count_q <= count_q + CntW'(1);
                2'b01:   count_q <= count_q - CntW'(1);
                default: count_q <= count_q;
            endcase
        end
    end

    // Storage needs no reset: nothing is visible until a push has written it.
    always_ff @(posedge clk) begin
        if (push) mem_q[wptr_q] <= wdata;
    end

    assign rdata = mem_q[rptr_q];
    assign count = count_q;
    assign full  = (count_q == CntW'(DEPTH));
    assign empty = (count_q == '0);

endmodule

// File: rtl/bitstream_feeder.sv
// JPEG scan byte stream to entropy-decoder word feeder: unstuffs 0xFF00, strips RSTn,
// stops at EOI, and packs bytes MSB-first into BUS_W words behind a FWFT FIFO.
module bitstream_feeder
    import bitstream_feeder_pkg::*;
#(
    parameter int unsigned BUS_W      = IN_BUS_WIDTH,
    parameter int unsigned FIFO_DEPTH = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [7:0]       s_byte,
    input  logic             s_valid,
    output logic             s_ready,
    input  logic             request,
    output logic [BUS_W-1:0] data_in,
    output logic             valid_in,
    output logic             done,
    output logic             marker_err
);

    localparam int unsigned Lanes    = BUS_W / 8;
    localparam int unsigned CntW     = (Lanes > 1) ? $clog2(Lanes) : 1;
    localparam int unsigned FifoCntW = $clog2(FIFO_DEPTH + 1);

    feed_state_e      state_q;
    logic [BUS_W-1:0] pack_q;
    logic [CntW-1:0]  pack_cnt_q;
    logic             marker_err_q;

    logic                accept, emit, last_lane, pad_push, push, pop;
    logic [7:0]          emit_byte;
    logic [BUS_W-1:0]    lane_word, pad_word, push_word, fifo_rdata;
    logic [FifoCntW-1:0] fifo_count;
    logic                fifo_full, fifo_empty;

    assign s_ready = ((state_q == StRun) || (state_q == StFfSeen)) &&
                     (fifo_count < FifoCntW'(FIFO_DEPTH));

    always_comb begin
        accept    = s_valid && s_ready;
        emit      = accept && (((state_q == StRun) && (s_byte != M_FILL)) ||
                               ((state_q == StFfSeen) && (s_byte == M_STUFF)));
        emit_byte = (state_q == StRun) ? s_byte : M_FILL;
        last_lane = (pack_cnt_q == CntW'(Lanes - 1));

        lane_word = pack_q;
        pad_word  = pack_q;
        for (int unsigned i = 0; i < Lanes; i++) begin
            if (pack_cnt_q == CntW'(i)) lane_word[BUS_W-1-8*i -: 8] = emit_byte;
            if (CntW'(i) >= pack_cnt_q) pad_word[BUS_W-1-8*i -: 8] = M_FILL;
        end

        // An empty packer never pads, so markers on a word boundary add no all-0xFF word.
        pad_push  = (pack_cnt_q != '0) &&
                    ((accept && (state_q == StFfSeen) && is_rst_marker(s_byte)) ||
                     ((state_q == StFlush) && !fifo_full));
        push      = (emit && last_lane) || pad_push;
        push_word = pad_push ? pad_word : lane_word;
        pop       = valid_in && request;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q      <= StIdle;
            pack_q       <= '0;
            pack_cnt_q   <= '0;
            marker_err_q <= 1'b0;
        end else begin
            if (emit) begin
                pack_q     <= lane_word;
                pack_cnt_q <= last_lane ? '0 : pack_cnt_q + CntW'(1);
            end
            if (pad_push) pack_cnt_q <= '0;

            unique case (state_q)
                StIdle, StDone: begin
                    if (start) begin
                        state_q      <= StRun;
                        marker_err_q <= 1'b0;
                    end
                end
                StRun: begin
                    if (accept && (s_byte == M_FILL)) state_q <= StFfSeen;
                end
                StFfSeen: begin
                    if (accept) begin
                        if (s_byte == M_EOI) begin
                            state_q <= StFlush;
                        end else if (s_byte == M_FILL) begin
                            state_q <= StFfSeen;
                        end else begin
                            if ((s_byte != M_STUFF) && !is_rst_marker(s_byte)) begin
                                marker_err_q <= 1'b1;
                            end
                            state_q <= StRun;
                        end
                    end
                end
                StFlush: begin
                    if ((pack_cnt_q == '0) && fifo_empty) state_q <= StDone;
                end
                default: state_q <= StIdle;
            endcase
        end
    end

    bitstream_feeder_word_fifo #(
        .WIDTH(BUS_W),
        .DEPTH(FIFO_DEPTH)
    ) u_word_fifo (
        .clk  (clk),
        .rst  (rst),
        .push (push),
        .wdata(push_word),
        .pop  (pop),
        .rdata(fifo_rdata),
        .count(fifo_count),
        .full (fifo_full),
        .empty(fifo_empty)
    );

    assign valid_in   = !fifo_empty;
    assign data_in    = fifo_empty ? '0 : fifo_rdata;
    assign done       = (state_q == StDone);
    assign marker_err = marker_err_q;

endmodule

// File: tb/tb_bitstream_feeder.sv
// Bench for bitstream_feeder: vector table, hand-written corner sequences, and random
// frames checked against a byte-queue reference model.
module tb_bitstream_feeder;

    typedef logic [7:0]  bq_t [$];
    typedef logic [31:0] wq_t [$];

    typedef struct {
        logic [79:0] stream;
        int          len;
        logic [63:0] words;
        int          nwords;
        logic        err;
    } vec_t;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        start = 1'b0;
    logic [7:0]  s_byte = 8'h00;
    logic        s_valid = 1'b0;
    logic        s_ready;
    logic        request = 1'b1;
    logic [31:0] data_in;
    logic        valid_in;
    logic        done;
    logic        marker_err;

    int   total = 0;
    int   bad = 0;
    logic rand_req = 1'b0;
    logic req_fixed = 1'b1;
    int   gap_max = 0;
    wq_t  got;

    bitstream_feeder #(
        .BUS_W     (32),
        .FIFO_DEPTH(8)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .start     (start),
        .s_byte    (s_byte),
        .s_valid   (s_valid),
        .s_ready   (s_ready),
        .request   (request),
        .data_in   (data_in),
        .valid_in  (valid_in),
        .done      (done),
        .marker_err(marker_err)
    );

    always #5 clk = ~clk;

    always @(posedge clk) begin
        #1;
        request = rand_req ? 1'($urandom_range(0, 1)) : req_fixed;
    end

    // A word is handed over on the next rising edge when valid_in && request here.
    always @(negedge clk) begin
        if (!rst && valid_in && request) got.push_back(data_in);
    end

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Called and returns at posedge+1.
    task automatic send_byte(input logic [7:0] b);
        int n = 0;
        s_byte  = b;
        s_valid = 1'b1;
        @(negedge clk);
        while (!s_ready && n < 500) begin
            @(negedge clk);
            n++;
        end
        if (!s_ready) check("s_ready_timeout", 0, 1);
        @(posedge clk);
        #1;
        s_valid = 1'b0;
        repeat ($urandom_range(0, gap_max)) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic pulse_start();
        start = 1'b1;
        @(posedge clk);
        #1;
        start = 1'b0;
        check("start_clears_done", done, 0);
        check("start_clears_err", marker_err, 0);
    endtask

    task automatic wait_done();
        int n = 0;
        while (!done && n < 3000) begin
            @(negedge clk);
            n++;
        end
        check("done_seen", done, 1);
        @(posedge clk);
        #1;
    endtask

    task automatic run_frame(input bq_t s);
        pulse_start();
        got.delete();
        foreach (s[i]) send_byte(s[i]);
        wait_done();
    endtask

    task automatic compare_words(input string name, input wq_t exp);
        check({name, "_count"}, got.size(), exp.size());
        for (int k = 0; k < exp.size() && k < got.size(); k++) begin
            check($sformatf("%s_word%0d", name, k), got[k], exp[k]);
        end
    endtask

    // Reference: unstuffed byte list, padded to a word boundary at RSTn/EOI, then grouped.
    function automatic void model(input bq_t s, output wq_t w, output logic err);
        bq_t  o;
        logic ff = 1'b0;
        logic stop = 1'b0;
        err = 1'b0;
        w = {};
        for (int k = 0; k < s.size() && !stop; k++) begin
            if (!ff) begin
                if (s[k] == 8'hFF) ff = 1'b1;
                else o.push_back(s[k]);
            end else if (s[k] == 8'h00) begin
                o.push_back(8'hFF);
                ff = 1'b0;
            end else if (s[k] == 8'hFF) begin
                ff = 1'b1;
            end else if (s[k] inside {[8'hD0:8'hD7]} || s[k] == 8'hD9) begin
                while (o.size() % 4 != 0) o.push_back(8'hFF);
                ff = 1'b0;
                stop = (s[k] == 8'hD9);
            end else begin
                err = 1'b1;
                ff = 1'b0;
            end
        end
        for (int k = 0; k + 3 < o.size(); k += 4) w.push_back({o[k], o[k+1], o[k+2], o[k+3]});
    endfunction

    initial begin
        #2ms;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        vec_t vecs[4];
        bq_t  s;
        wq_t  e;
        logic exp_err;
        logic [7:0] b0, b1, b2, b3;

        vecs[0] = '{80'h12345678FFD9,         6, 64'h12345678,         1, 1'b0};
        vecs[1] = '{80'hABFF00CDEFFFD9,       7, 64'hABFFCDEF,         1, 1'b0};
        vecs[2] = '{80'h1122FFD333FFD9,       7, 64'h1122FFFF33FFFFFF, 2, 1'b0};
        vecs[3] = '{80'h01FFC40203_04FFD9,    8, 64'h01020304,         1, 1'b1};

        // Reset state, both during and after reset.
        repeat (3) @(posedge clk);
        @(negedge clk);
        check("rst_s_ready", s_ready, 0);
        check("rst_valid_in", valid_in, 0);
        check("rst_data_in", data_in, 0);
        check("rst_done", done, 0);
        check("rst_marker_err", marker_err, 0);
        @(posedge clk);
        #1;
        rst = 1'b0;
        @(posedge clk);
        #1;
        check("idle_s_ready", s_ready, 0);
        check("idle_valid_in", valid_in, 0);

        // Word appears on data_in the cycle after its last byte.
        pulse_start();
        got.delete();
        send_byte(8'h12);
        send_byte(8'h34);
        send_byte(8'h56);
        check("lat_not_yet", valid_in, 0);
        send_byte(8'h78);
        check("lat_valid", valid_in, 1);
        check("lat_data", data_in, 32'h12345678);
        send_byte(8'hFF);
        send_byte(8'hD9);
        wait_done();
        check("lat_done_valid", valid_in, 0);
        e = {32'h12345678};
        compare_words("lat", e);

        // Table vectors.
        for (int v = 0; v < 4; v++) begin
            s = {};
            e = {};
            for (int i = 0; i < vecs[v].len; i++) begin
                s.push_back(8'(vecs[v].stream >> (8 * (vecs[v].len - 1 - i))));
            end
            for (int k = 0; k < vecs[v].nwords; k++) begin
                e.push_back(32'(vecs[v].words >> (32 * (vecs[v].nwords - 1 - k))));
            end
            run_frame(s);
            compare_words($sformatf("vec%0d", v), e);
            check($sformatf("vec%0d_marker_err", v), marker_err, vecs[v].err);
        end

        // Backpressure: 8 words fill the FIFO, head held, then drain 10 words in order.
        req_fixed = 1'b0;
        pulse_start();
        got.delete();
        for (int i = 1; i <= 32; i++) send_byte(8'(i));
        check("bp_s_ready_low", s_ready, 0);
        check("bp_valid", valid_in, 1);
        check("bp_head", data_in, 32'h01020304);
        repeat (3) @(posedge clk);
        #1;
        check("bp_hold_head", data_in, 32'h01020304);
        check("bp_hold_ready", s_ready, 0);
        req_fixed = 1'b1;
        for (int i = 33; i <= 40; i++) send_byte(8'(i));
        send_byte(8'hFF);
        send_byte(8'hD9);
        wait_done();
        e = {};
        for (int k = 0; k < 10; k++) begin
            b0 = 8'(4 * k + 1);
            b1 = 8'(4 * k + 2);
            b2 = 8'(4 * k + 3);
            b3 = 8'(4 * k + 4);
            e.push_back({b0, b1, b2, b3});
        end
        compare_words("bp", e);

        // Reset mid-word discards buffered and partial data immediately.
        req_fixed = 1'b0;
        pulse_start();
        got.delete();
        send_byte(8'h11);
        send_byte(8'h22);
        send_byte(8'h33);
        send_byte(8'h44);
        send_byte(8'hAA);
        send_byte(8'hBB);
        check("mid_pre_valid", valid_in, 1);
        rst = 1'b1;
        #1;
        check("mid_valid_in", valid_in, 0);
        check("mid_s_ready", s_ready, 0);
        check("mid_data_in", data_in, 0);
        @(posedge clk);
        #1;
        rst = 1'b0;
        req_fixed = 1'b1;
        @(posedge clk);
        #1;
        s = {8'h01, 8'h02, 8'h03, 8'h04, 8'hFF, 8'hD9};
        run_frame(s);
        e = {32'h01020304};
        compare_words("mid", e);

        // Random frames against the reference model.
        rand_req = 1'b1;
        gap_max = 2;
        for (int f = 0; f < 25; f++) begin
            s = {};
            for (int k = 0, n = $urandom_range(1, 24); k < n; k++) begin
                if ($urandom_range(0, 9) < 7) begin
                    s.push_back(8'($urandom_range(0, 254)));
                end else begin
                    s.push_back(8'hFF);
                    case ($urandom_range(0, 3))
                        0: s.push_back(8'h00);
                        1: begin
                            s.push_back(8'hFF);
                            s.push_back(8'h00);
                        end
                        2: s.push_back(8'(8'hD0 + $urandom_range(0, 7)));
                        default: s.push_back(8'hC4);
                    endcase
                end
            end
            s.push_back(8'hFF);
            s.push_back(8'hD9);
            model(s, e, exp_err);
            run_frame(s);
            compare_words($sformatf("rnd%0d", f), e);
            check($sformatf("rnd%0d_marker_err", f), marker_err, exp_err);
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
